// File: rtl/pipeline_hazard_sequencer.sv
// pipeline_hazard_sequencer: stall/flush sequencer for the 5-stage pipeline; stall counter built only when PERF_CNT_EN is defined
module pipeline_hazard_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             id_opcode,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic                   ex_memread,
  input  logic [4:0]             ex_rt,
  input  logic                   ex_branch_taken,
  input  logic                   ex_jump,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  output logic                   pc_write,
  output logic                   ifid_write,
  output logic                   ifid_flush,
  output logic                   idex_flush,
  output logic                   pipe_hold,
  output logic                   mem_start,
  output logic                   mem_err,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  localparam int TW = $clog2(MEM_TIMEOUT + 2);
  typedef enum logic {S_RUN, S_MEMWAIT} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic redirect, load_use, timeout, release_c, hold;
  assign redirect  = ex_branch_taken | ex_jump;
  assign load_use  = ex_memread && ex_rt != 5'd0 &&
                     (ex_rt == id_rs || (ex_rt == id_rt && id_opcode inside {6'b000000, 6'b101011, 6'b000100}));
  assign timeout   = MEM_TIMEOUT != 0 && state_q == S_MEMWAIT && !mem_ready && tmo_q == TW'(MEM_TIMEOUT - 1);
  assign release_c = state_q == S_MEMWAIT && (mem_ready || timeout);
  assign hold      = (state_q == S_RUN && mem_req) || (state_q == S_MEMWAIT && !release_c);
  // state and wait-cycle counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RUN;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
    end
  end
  // next state and hazard responses; hold beats redirect beats load-use, all outputs quiet in reset
  always_comb begin
    state_d    = state_q == S_RUN ? (mem_req ? S_MEMWAIT : S_RUN) : (release_c ? S_RUN : S_MEMWAIT);
    tmo_d      = (state_q == S_MEMWAIT && !release_c) ? tmo_q + 1'b1 : '0;
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    pipe_hold  = 1'b0;
    mem_start  = 1'b0;
    mem_err    = 1'b0;
    if (!reset) begin
      mem_err = timeout;
      if (hold) begin
        pipe_hold = 1'b1;
        mem_start = state_q == S_RUN;
      end else if (redirect) begin
        {pc_write, ifid_write, ifid_flush, idex_flush} = 4'b1111;
      end else if (load_use) begin
        idex_flush = 1'b1;
      end else begin
        {pc_write, ifid_write} = 2'b11;
      end
    end
  end
`ifdef PERF_CNT_EN
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  assign stall_d = (!pc_write && !(&stall_q)) ? stall_q + 1'b1 : stall_q;
  // saturating count of cycles with the PC frozen
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_q <= '0;
    else stall_q <= stall_d;
  end
  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// tb_pipeline_hazard_sequencer: directed scoreboard bench for two sequencer configurations
module tb_pipeline_hazard_sequencer;
  logic clk = 1'b0, reset = 1'b1;
  logic [5:0] id_opcode;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic ex_memread, ex_branch_taken, ex_jump, mem_req, mem_ready;
  logic pcw0, ifw0, iff0, ief0, ph0, ms0, me0, pcw1, ifw1, iff1, ief1, ph1, ms1, me1;
  logic [15:0] sc0;
  logic [1:0] sc1;
  logic [6:0] o0, o1;
  typedef struct {string tag; logic [6:0] e0; logic [6:0] e1;} exp_t;
  exp_t sbq[$];
  int checks = 0, errors = 0, m0 = 0, m1 = 0;
  localparam logic [6:0] ZERO = 7'b0000000, NORM = 7'b1100000, LU = 7'b0001000, FLUSH = 7'b1111000,
                         HOLD0 = 7'b0000110, HOLD = 7'b0000100, ERR = 7'b1100001;
  always #5 clk = ~clk;
  assign o0 = {pcw0, ifw0, iff0, ief0, ph0, ms0, me0};
  assign o1 = {pcw1, ifw1, iff1, ief1, ph1, ms1, me1};
  pipeline_hazard_sequencer dut0 (
    .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(pcw0), .ifid_write(ifw0), .ifid_flush(iff0),
    .idex_flush(ief0), .pipe_hold(ph0), .mem_start(ms0), .mem_err(me0), .stall_cnt(sc0));
  pipeline_hazard_sequencer #(.MEM_TIMEOUT(4), .STALL_CNT_W(2)) dut1 (
    .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(pcw1), .ifid_write(ifw1), .ifid_flush(iff1),
    .idex_flush(ief1), .pipe_hold(ph1), .mem_start(ms1), .mem_err(me1), .stall_cnt(sc1));
  task automatic si(input logic mr, input logic [4:0] er, rs, rt, input logic [5:0] op,
                    input logic br, jp, mq, my);
    ex_memread = mr; ex_rt = er; id_rs = rs; id_rt = rt; id_opcode = op;
    ex_branch_taken = br; ex_jump = jp; mem_req = mq; mem_ready = my;
  endtask
  task automatic cyc(input string tag, input logic [6:0] e0, input logic [6:0] e1);
    exp_t x;
    logic [15:0] es0;
    logic [1:0] es1;
    x.tag = tag; x.e0 = e0; x.e1 = e1;
    sbq.push_back(x);
    @(negedge clk);
    x = sbq.pop_front();
    checks++;
    assert (o0 === x.e0) else begin errors++; $error("FAIL %s dut0 outputs observed=%b expected=%b", x.tag, o0, x.e0); end
    checks++;
    assert (o1 === x.e1) else begin errors++; $error("FAIL %s dut1 outputs observed=%b expected=%b", x.tag, o1, x.e1); end
    @(posedge clk);
    #1;
    if (reset) begin
      m0 = 0; m1 = 0;
    end else begin
      if (!x.e0[6] && m0 < 65535) m0++;
      if (!x.e1[6] && m1 < 3) m1++;
    end
`ifdef PERF_CNT_EN
    es0 = 16'(m0); es1 = 2'(m1);
`else
    es0 = '0; es1 = '0;
`endif
    checks++;
    assert (sc0 === es0) else begin errors++; $error("FAIL %s dut0 stall_cnt observed=%0d expected=%0d", x.tag, sc0, es0); end
    checks++;
    assert (sc1 === es1) else begin errors++; $error("FAIL %s dut1 stall_cnt observed=%0d expected=%0d", x.tag, sc1, es1); end
  endtask
  initial begin
    si(1, 2, 2, 0, 0, 1, 0, 1, 0);
    cyc("reset", ZERO, ZERO);
    reset = 1'b0;
    si(0, 0, 0, 0, 0, 0, 0, 0, 0); cyc("idle", NORM, NORM);
    si(1, 2, 2, 0, 0, 0, 0, 0, 0); cyc("lu_rs", LU, LU);
    si(0, 0, 0, 0, 0, 0, 0, 0, 0); cyc("lu_clear", NORM, NORM);
    si(1, 0, 0, 0, 0, 0, 0, 0, 0); cyc("rt_zero", NORM, NORM);
    si(1, 5, 1, 5, 6'b100011, 0, 0, 0, 0); cyc("lw_rt_nostall", NORM, NORM);
    si(1, 5, 1, 5, 6'b000000, 0, 0, 0, 0); cyc("lu_rtype", LU, LU);
    si(1, 5, 1, 5, 6'b101011, 0, 0, 0, 0); cyc("lu_sw", LU, LU);
    si(1, 5, 1, 5, 6'b000100, 0, 0, 0, 0); cyc("lu_beq", LU, LU);
    si(0, 0, 0, 0, 0, 0, 0, 1, 0); cyc("mw_c0", HOLD0, HOLD0);
    for (int i = 0; i < 3; i++) cyc("mw_wait", HOLD, HOLD);
    si(0, 0, 0, 0, 0, 0, 0, 1, 1); cyc("mw_release", NORM, NORM);
    si(0, 0, 0, 0, 0, 0, 0, 0, 0); cyc("mw_after", NORM, NORM);
    si(0, 0, 0, 0, 0, 0, 0, 1, 0); cyc("to_c0", HOLD0, HOLD0);
    for (int i = 0; i < 3; i++) cyc("to_wait", HOLD, HOLD);
    cyc("to_err", HOLD, ERR);
    si(0, 0, 0, 0, 0, 0, 0, 0, 0); cyc("to_after", HOLD, NORM);
    si(0, 0, 0, 0, 0, 0, 0, 0, 1); cyc("to_release0", NORM, NORM);
    si(0, 0, 0, 0, 0, 0, 0, 0, 0); cyc("to_idle", NORM, NORM);
    si(0, 0, 0, 0, 0, 0, 0, 1, 1); cyc("br_c0_ready_ignored", HOLD0, HOLD0);
    si(0, 0, 0, 0, 0, 1, 0, 1, 1); cyc("br_release", FLUSH, FLUSH);
    si(0, 0, 0, 0, 0, 0, 0, 0, 0); cyc("br_after", NORM, NORM);
    si(0, 0, 0, 0, 0, 0, 0, 1, 0); cyc("lur_c0", HOLD0, HOLD0);
    si(1, 3, 3, 0, 0, 0, 0, 1, 1); cyc("lu_release", LU, LU);
    si(0, 0, 0, 0, 0, 0, 0, 0, 0); cyc("lur_after", NORM, NORM);
    si(1, 2, 2, 0, 0, 1, 0, 0, 0); cyc("br_over_lu", FLUSH, FLUSH);
    si(1, 2, 2, 0, 0, 1, 1, 0, 0); cyc("br_and_j", FLUSH, FLUSH);
    si(0, 0, 0, 0, 0, 0, 1, 0, 0); cyc("jump", FLUSH, FLUSH);
    si(0, 0, 0, 0, 0, 0, 0, 1, 0); cyc("rst_c0", HOLD0, HOLD0);
    cyc("rst_wait", HOLD, HOLD);
    reset = 1'b1;
    cyc("rst_mid", ZERO, ZERO);
    reset = 1'b0;
    si(0, 0, 0, 0, 0, 0, 0, 0, 0); cyc("rst_after", NORM, NORM);
    si(1, 7, 7, 0, 0, 0, 0, 0, 0); cyc("lu_post_rst", LU, LU);
    si(0, 0, 0, 0, 0, 0, 0, 0, 0); cyc("final", NORM, NORM);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_sequencer.md
Name: pipeline_hazard_sequencer

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Holds the whole pipeline while the MEM stage waits on the data-memory handshake.
- Inserts a bubble on load-use hazards and flushes IF/ID and ID/EX on a taken branch or jump.
- Sits beside the ID/EX control decode; drives the write-enables and flushes of PC, IF/ID and the downstream pipeline registers.

Parameters:
MEM_TIMEOUT, 15, max cycles waiting for mem_ready before abort; 0 disables the timeout.
STALL_CNT_W, 16, width of the stall performance counter.

Ports:
clk  input  1  pipeline clock
reset  input  1  asynchronous, active-high reset
id_opcode  input  6  opcode of the instruction in ID
id_rs  input  5  rs field in ID
id_rt  input  5  rt field in ID
ex_memread  input  1  instruction in EX is lw
ex_rt  input  5  destination rt of the instruction in EX
ex_branch_taken  input  1  beq in EX resolved taken
ex_jump  input  1  j in EX
mem_req  input  1  instruction in MEM needs memory (MemRead|MemWrite)
mem_ready  input  1  memory transfer complete
pc_write  output  1  PC load enable
ifid_write  output  1  IF/ID load enable
ifid_flush  output  1  zero IF/ID
idex_flush  output  1  load bubble (all-zero control) into ID/EX
pipe_hold  output  1  freeze ID/EX, EX/MEM, MEM/WB
mem_start  output  1  one-cycle memory request strobe
mem_err  output  1  one-cycle timeout pulse
stall_cnt  output  STALL_CNT_W  saturating stall-cycle count

Behaviour:
- States: S_RUN, S_MEMWAIT. State and the timeout counter are registered; outputs are combinational from state and inputs.
- Reset (async, high): state=S_RUN, timeout counter=0, stall_cnt=0. While reset is high, every output is 0.
- Reset mid-S_MEMWAIT: returns to S_RUN with no mem_err.
- Evaluation order in S_RUN: mem_req first, then branch/jump, then load-use.
- S_RUN, mem_req=1:
  - mem_start=1, pipe_hold=1, pc_write=0, ifid_write=0, flushes=0.
  - Next state S_MEMWAIT; timeout counter cleared.
  - mem_ready is ignored in S_RUN, so the minimum hold is 2 cycles.
- S_MEMWAIT, mem_ready=0:
  - Same outputs as the entry cycle but mem_start=0; counter increments.
  - If MEM_TIMEOUT!=0 and the counter reaches MEM_TIMEOUT-1: mem_err=1 this cycle, and the cycle is treated as a release cycle.
- Release cycle (S_MEMWAIT with mem_ready=1, or timeout):
  - pipe_hold=0, next state S_RUN.
  - mem_req is ignored this cycle because it still reflects the completing instruction.
  - Branch/jump and load-use rules are evaluated exactly as in S_RUN, so a redirect in EX is never lost.
- Branch/jump (ex_branch_taken|ex_jump) in S_RUN with mem_req=0, or in a release cycle:
  - ifid_flush=1, idex_flush=1, pc_write=1, ifid_write=1.
  - Overrides load-use.
- Load-use, evaluated when there is no branch/jump and no hold:
  - Condition: ex_memread=1, ex_rt!=0, and either ex_rt==id_rs or (ex_rt==id_rt with id_opcode in {000000, 101011, 000100}).
  - Response: pc_write=0, ifid_write=0, idex_flush=1.
- Otherwise: pc_write=1, ifid_write=1, all else 0.
- ex_branch_taken and ex_jump asserted together: treated as a single flush.
- stall_cnt increments every non-reset cycle with pc_write=0; it saturates at all-ones and does not wrap.

Optional Feature:
PERF_CNT_EN
- Defined: the stall_cnt register is implemented as specified.
- Undefined: no counter register is synthesized; stall_cnt is tied to 0.

Test Plan:
- lw $2 in EX (ex_memread=1, ex_rt=2), add in ID with id_rs=2 -> one cycle of pc_write=0, ifid_write=0, idex_flush=1; next cycle pc_write=1.
- ex_memread=1, ex_rt=0, id_rs=0 -> no stall.
- ex_rt=5, id_rt=5, id_opcode=100011 -> no stall.
- mem_req=1, mem_ready high after 3 S_MEMWAIT cycles -> mem_start pulse in cycle 0; pipe_hold=1 for cycles 0-3; released in cycle 4.
- MEM_TIMEOUT=4, mem_ready stuck 0 -> mem_err pulse in the 4th S_MEMWAIT cycle; pipe_hold=0 in that cycle; state back to S_RUN.
- ex_branch_taken=1 on the release cycle of a memory wait -> ifid_flush=1, idex_flush=1, pipe_hold=0 in that same cycle.
- Branch plus load-use at the same time -> flushes only, pc_write=1.
- reset pulse mid-S_MEMWAIT -> all outputs 0 immediately; S_RUN afterwards.
- With PERF_CNT_EN: 3 stalls -> stall_cnt=3.
- With STALL_CNT_W=2 and 5 stalls -> stall_cnt=3 (saturated).
